// File: rtl/cycle_count_display.sv
// Cycle-count display: converts a 32-bit binary count to 10 BCD digits with a
// 32-step double-dabble FSM, latches the result into display registers, and
// scans the low 8 digits onto a multiplexed active-low 7-segment display with
// leading-zero blanking. Digits 8..9 only feed overflow and blanking.
module cycle_count_display #(
  parameter int REFRESH_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] count_in,
  input  logic        freeze,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        overflow,
  output logic        bcd_valid
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             bin_q, bin_d;
  logic [39:0]             bcd_q, bcd_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [39:0]             disp_q, disp_d;
  logic                    ovf_q, ovf_d;
  logic                    vld_q, vld_d;
  logic [REFRESH_BITS-1:0] scan_q, scan_d;
  logic [7:0]              an_q, an_d;
  logic [6:0]              seg_q, seg_d;

  logic [39:0] adj;
  logic [2:0]  idx;
  logic [3:0]  cur_digit;
  logic [9:0]  zero_above;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  // Conversion FSM: next state, double-dabble step and commit to display.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    vld_d   = 1'b0;
    adj     = bcd_q;
    for (int i = 0; i < 10; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: if (!freeze) state_d = LOAD;
      LOAD: begin
        bin_d   = count_in;
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj[38:0], bin_q, 1'b0};
        cnt_d          = cnt_q + 5'd1;
        // cnt_q==31 marks the 32nd shift; leave after it
        if (cnt_q == 5'd31) state_d = DONE;
      end
      DONE: begin
        disp_d  = bcd_q;
        ovf_d   = |bcd_q[39:32];
        vld_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan path: pick the active digit, blank leading zeros, register an/seg.
  always_comb begin
    scan_d     = scan_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
    idx        = scan_q[REFRESH_BITS-1 -: 3];
    cur_digit  = disp_q[{idx, 2'b00} +: 4];
    zero_above = '0;
    zero_above[9] = (disp_q[39:36] == 4'd0);
    for (int k = 8; k >= 0; k--) begin
      zero_above[k] = zero_above[k+1] && (disp_q[4*k +: 4] == 4'd0);
    end
    an_d  = ~(8'b0000_0001 << idx);
    seg_d = enc(cur_digit);
    if (idx != 3'd0 && zero_above[idx]) seg_d = 7'b1111111;
  end

  // All state; synchronous reset wins over everything, dropping any conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      scan_q  <= '0;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      scan_q  <= scan_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = 1'b1;
  assign overflow  = ovf_q;
  assign bcd_valid = vld_q;

endmodule

// File: tb/tb_cycle_count_display.sv
// Bench for cycle_count_display: each started conversion pushes its value and
// LOAD cycle to a scoreboard; the commit monitor pops on bcd_valid and checks
// latency and overflow; the scanned display is then decoded digit by digit.
module tb_cycle_count_display;
  localparam int RB = 6;  // 8-cycle digit slot, 64-cycle full scan

  logic        clk = 1'b0;
  logic        rst, freeze, dp, overflow, bcd_valid;
  logic [31:0] count_in;
  logic [7:0]  an;
  logic [6:0]  seg;

  cycle_count_display #(.REFRESH_BITS(RB)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .freeze(freeze),
    .an(an), .seg(seg), .dp(dp), .overflow(overflow), .bcd_valid(bcd_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint val;
    int     load_cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         commits = 0;
  int         n_chk = 0, n_err = 0;
  logic [6:0] segtab[10];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input longint v, input int k);
    longint p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (k > 0 && v < p) return 7'h7F;
    return segtab[int'((v / p) % 10)];
  endfunction

  // Commit monitor: every bcd_valid must match a scoreboard entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && bcd_valid === 1'b1) begin
      if (sb.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("latency", 64'(cyc - mon_e.load_cyc), 34);
        chk("overflow", {63'd0, overflow}, {63'd0, mon_e.val > 64'd99999999});
      end
      commits++;
    end
  end

  // Start one conversion: freeze low for lowc cycles, then value changes to after.
  task automatic conv(input longint v, input int lowc, input longint after);
    exp_t e;
    count_in   = 32'(v);
    e.val      = v;
    e.load_cyc = cyc + 1;
    sb.push_back(e);
    freeze = 1'b0;
    repeat (lowc) @(negedge clk);
    freeze   = 1'b1;
    count_in = 32'(after);
  endtask

  task automatic wait_commit(input int c0);
    bit seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (commits > c0) seen = 1;
    end
    if (!seen) chk("commit_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic check_disp(input string tag, input longint v);
    logic [6:0] seen[8];
    int bad = 0;
    for (int k = 0; k < 8; k++) seen[k] = 'x;
    for (int s = 0; s < 72; s++) begin
      @(negedge clk);
      if ($countones(~an) != 1) bad++;
      else for (int k = 0; k < 8; k++) if (an[k] == 1'b0) seen[k] = seg;
    end
    chk({tag, "_onehot"}, 64'(bad), 0);
    chk({tag, "_dp"}, {63'd0, dp}, 1);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_d%0d", tag, k), {57'd0, seen[k]}, {57'd0, exp_seg(v, k)});
  endtask

  initial begin
    int c0;
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    segtab[0] = 7'b1000000; segtab[1] = 7'b1111001; segtab[2] = 7'b0100100;
    segtab[3] = 7'b0110000; segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
    segtab[6] = 7'b0000010; segtab[7] = 7'b1111000; segtab[8] = 7'b0000000;
    segtab[9] = 7'b0010000;

    rst = 1'b1; freeze = 1'b1; count_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_an", {56'd0, an}, 64'hFF);
    chk("rst_seg", {57'd0, seg}, 64'h7F);
    chk("rst_ovf", {63'd0, overflow}, 0);
    chk("rst_vld", {63'd0, bcd_valid}, 0);
    rst = 1'b0;
    check_disp("rst", 0);

    c0 = commits; conv(12345678, 1, 12345678); wait_commit(c0);
    check_disp("mid", 12345678);

    c0 = commits; conv(305, 1, 305); wait_commit(c0);
    check_disp("blank", 305);

    c0 = commits; conv(64'hFFFFFFFF, 1, 64'hFFFFFFFF); wait_commit(c0);
    check_disp("max", 64'hFFFFFFFF);

    // freeze raised mid-SHIFT, input changes afterwards: 42 must still commit
    c0 = commits; conv(42, 5, 99); wait_commit(c0);
    c0 = commits;
    check_disp("frz", 42);
    repeat (30) @(negedge clk);
    chk("frz_no_more_valid", 64'(commits), 64'(c0));
    c0 = commits; conv(99, 1, 99); wait_commit(c0);
    check_disp("unfrz", 99);

    // reset on the 10th SHIFT cycle: nothing commits, display back to 0
    c0 = commits;
    count_in = 32'd777;
    freeze = 1'b0;
    @(negedge clk);
    freeze = 1'b1;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_an", {56'd0, an}, 64'hFF);
    chk("rstmid_seg", {57'd0, seg}, 64'h7F);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    chk("rstmid_no_valid", 64'(commits), 64'(c0));
    chk("rstmid_ovf", {63'd0, overflow}, 0);
    check_disp("rstmid", 0);
    chk("sb_empty", 64'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
